// File: rtl/fe_pkg.sv
// Shared front-end types: PC/entry payloads, speculation tracker states and branch-type codes.
package fe_pkg;

    localparam int unsigned PC_WIDTH  = 16;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TAG_WIDTH = $clog2(DEPTH);
    localparam int unsigned PTR_WIDTH = TAG_WIDTH + 1;

    typedef logic [PC_WIDTH-1:0]  pc_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    typedef struct packed {
        logic taken;
        pc_t  fallback_pc;
    } spec_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } spec_state_e;

    // Branch-type encoding shared with the static predictor
    typedef enum logic [1:0] {
        BR_CC = 2'b00,
        BR_B  = 2'b01,
        BR_BL = 2'b10,
        BR_BX = 2'b11
    } br_type_e;

endpackage

// File: rtl/branch_spec_tracker_if.sv
// Fetch/back-end handshake bundle for the speculative branch tracker.
interface branch_spec_tracker_if;
    import fe_pkg::*;

    logic  alloc_v_i;
    logic  alloc_taken_i;
    pc_t   alloc_fallback_pc_i;
    logic  alloc_ready_o;
    tag_t  alloc_tag_o;
    logic  resolve_v_i;
    tag_t  resolve_tag_i;
    logic  resolve_taken_i;
    logic  redirect_v_o;
    pc_t   redirect_pc_o;
    logic  flush_o;
    ptr_t  count_o;
    logic  error_o;

    modport master (
        output alloc_v_i, alloc_taken_i, alloc_fallback_pc_i,
        output resolve_v_i, resolve_tag_i, resolve_taken_i,
        input  alloc_ready_o, alloc_tag_o, redirect_v_o, redirect_pc_o,
        input  flush_o, count_o, error_o
    );

    modport slave (
        input  alloc_v_i, alloc_taken_i, alloc_fallback_pc_i,
        input  resolve_v_i, resolve_tag_i, resolve_taken_i,
        output alloc_ready_o, alloc_tag_o, redirect_v_o, redirect_pc_o,
        output flush_o, count_o, error_o
    );

endinterface

// File: rtl/spec_fifo.sv
// In-order entry store with wrap-bit pointers; clear resets both pointers and wins over push/pop.
module spec_fifo
    import fe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  spec_entry_t push_data,
    input  logic        pop,
    input  logic        clear,
    output spec_entry_t head,
    output tag_t        wr_idx,
    output tag_t        rd_idx,
    output logic        full,
    output logic        empty,
    output ptr_t        count
);

    spec_entry_t mem [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        end
    end

    // Payload needs no reset: validity is carried entirely by the pointers
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_idx] <= push_data;
    end

    assign wr_idx = wr_ptr[TAG_WIDTH-1:0];
    assign rd_idx = rd_ptr[TAG_WIDTH-1:0];
    assign head   = mem[rd_idx];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[TAG_WIDTH] != rd_ptr[TAG_WIDTH]);
    assign count  = wr_ptr - rd_ptr;

endmodule

// File: rtl/branch_spec_tracker.sv
// Tracks outstanding speculative branches; on a mispredicted head it redirects fetch and squashes younger entries.
module branch_spec_tracker
    import fe_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    branch_spec_tracker_if.slave  bus
);

    spec_state_e state_q, state_d;
    pc_t         redirect_pc_q, redirect_pc_d;
    logic        error_q, error_d;

    logic        push, pop, clear;
    logic        alloc_ready, alloc_fire;
    spec_entry_t head;
    tag_t        wr_idx, rd_idx;
    logic        full, empty;
    ptr_t        count;

    spec_fifo u_fifo (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .push      (push),
        .push_data ('{taken: bus.alloc_taken_i, fallback_pc: bus.alloc_fallback_pc_i}),
        .pop       (pop),
        .clear     (clear),
        .head      (head),
        .wr_idx    (wr_idx),
        .rd_idx    (rd_idx),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Ready depends only on registered state, never on a same-cycle resolve
    assign alloc_ready = (state_q == NORMAL) && !full;
    assign alloc_fire  = bus.alloc_v_i && alloc_ready;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= NORMAL;
            redirect_pc_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        error_d       = error_q;
        push          = 1'b0;
        pop           = 1'b0;
        clear         = 1'b0;
        unique case (state_q)
            NORMAL: begin
                push = alloc_fire;
                if (bus.resolve_v_i) begin
                    if (empty || (bus.resolve_tag_i != rd_idx)) begin
                        error_d = 1'b1;
                    end else if (bus.resolve_taken_i == head.taken) begin
                        pop = 1'b1;
                    end else begin
                        // Same-cycle alloc is younger than the mispredict: handshake completes, entry dropped
                        push          = 1'b0;
                        clear         = 1'b1;
                        redirect_pc_d = head.fallback_pc;
                        state_d       = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = NORMAL;
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    assign bus.alloc_ready_o = alloc_ready;
    assign bus.alloc_tag_o   = wr_idx;
    assign bus.redirect_v_o  = (state_q == FLUSH);
    assign bus.flush_o       = (state_q == FLUSH);
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.count_o       = count;
    assign bus.error_o       = error_q;

endmodule

// File: doc/branch_spec_tracker.md
# branch_spec_tracker

Front-end tracker for speculative branches issued by the static branch predictor. Each fetched branch flagged speculative is allocated an in-order entry holding its predicted direction and the PC of the not-predicted path. When the back end resolves the oldest entry, the tracker compares the actual direction with the prediction. On a mismatch it issues a one-cycle redirect/flush to fetch and discards all younger entries. It also stalls fetch when the tracking window is full.

## Interface
- PC_WIDTH, 16, width of PCs carried per entry
- DEPTH, 4, max outstanding speculative branches; power of two, ≥2
- TAG_WIDTH, $clog2(DEPTH), derived; tag = write-pointer index
---
- clk_i  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- alloc_v_i  in  1  fetch presents a speculative branch (speculative_o from predictor)
- alloc_taken_i  in  1  predicted direction (take_branch_o from predictor)
- alloc_fallback_pc_i  in  PC_WIDTH  PC of the path NOT predicted
- alloc_ready_o  out  1  entry available; handshake = alloc_v_i & alloc_ready_o
- alloc_tag_o  out  TAG_WIDTH  tag assigned to the branch accepted this cycle
- resolve_v_i  in  1  back end resolves the oldest outstanding branch
- resolve_tag_i  in  TAG_WIDTH  tag being resolved; must equal head tag
- resolve_taken_i  in  1  actual direction
- redirect_v_o  out  1  one-cycle pulse: fetch must restart at redirect_pc_o
- redirect_pc_o  out  PC_WIDTH  fallback PC of the mispredicted entry
- flush_o  out  1  one-cycle pulse, coincident with redirect_v_o; kill younger in-flight work
- count_o  out  TAG_WIDTH+1  outstanding entries
- error_o  out  1  sticky protocol error until reset

## Operation
- Storage: DEPTH entries of {taken, fallback_pc}. Read and write pointers are TAG_WIDTH+1 bits; the MSB is the wrap bit. full = same index with different wrap; empty = pointers equal.
- FSM states: NORMAL, FLUSH. Reset → NORMAL.
- NORMAL:
  - Accepted alloc writes the entry at wr_ptr, then wr_ptr+1. alloc_tag_o = wr_ptr index.
  - resolve_v_i when not empty compares resolve_taken_i with head.taken:
    - Match: rd_ptr+1 (retire).
    - Mismatch: register redirect_pc_o = head.fallback_pc, set both pointers to 0, go to FLUSH.
- FLUSH (exactly one cycle):
  - redirect_v_o = flush_o = 1.
  - alloc_ready_o = 0; resolve_v_i ignored (not an error).
  - Next state NORMAL.
- alloc_ready_o = (state==NORMAL) & !full. It is computed from registered state only and never depends on the same-cycle resolve.
- Simultaneous alloc + matching resolve: both occur; count unchanged.
- Simultaneous alloc + mispredicting resolve: the alloc handshake completes but the entry is squashed and not written, because it is younger than the mispredicted branch.
- Full + resolve in the same cycle: alloc still refused that cycle.
- Error cases set error_o and cause no other state change:
  - resolve when empty;
  - resolve_tag_i ≠ head index.
- Pointer wrap-around is natural modulo 2·DEPTH; tags repeat every DEPTH allocations.
- Reset asserted mid-operation: all entries dropped immediately and asynchronously. Any pending redirect is cancelled.
- Reset values: alloc_ready_o=1, alloc_tag_o=0, redirect_v_o=0, redirect_pc_o=0, flush_o=0, count_o=0, error_o=0.

## Timing
- Alloc: accepted on the handshake edge; count_o reflects it the next cycle.
- Retire: 1 cycle, resolve edge → count_o updated.
- Mispredict: resolve at edge N → redirect_v_o/flush_o high for the cycle after edge N, with count_o=0 and alloc_ready_o=0. alloc_ready_o returns to 1 after edge N+1.
- Minimum alloc-to-resolve distance is 1 cycle; same-cycle alloc+resolve of the same entry is not supported (empty → error).
- No combinational path from any input to redirect_v_o, redirect_pc_o, flush_o or alloc_ready_o.

## Structure
- Shared package fe_pkg holds:
  - pc_t (PC_WIDTH logic vector);
  - spec_entry_t {taken, fallback_pc};
  - spec_state_e {NORMAL, FLUSH};
  - branch-type constants (CC=00, B=01, BL=10, BX=11) shared with the predictor.
- One sub-module, spec_fifo: pointer/storage FIFO with a synchronous clear input. The FSM and compare logic stay in branch_spec_tracker.

## Test plan
- Reset, 4 allocs (taken=1, PCs 0x0010..0x0013) → tags 0,1,2,3; count_o=4; alloc_ready_o=0; 5th alloc refused.
- From full, resolve tag0 taken=1 → count_o=3, no redirect; next alloc gets tag 0 (wrap).
- Allocate tag0 taken=0 PC=0x1234, tag1 taken=1; resolve tag0 taken=1 → redirect_v_o=flush_o=1 for one cycle with redirect_pc_o=0x1234; count_o=0; alloc_ready_o=0 that cycle, then 1.
- Alloc (PC 0x0050) in the same cycle as a mispredicting resolve → after FLUSH count_o=0; the next alloc gets tag 0.
- Resolve while empty, and resolve with tag 2 while head is 1 → error_o=1, count unchanged, error_o stays 1 until reset_n_i low.
- Assert reset_n_i in the FLUSH cycle → redirect_v_o drops immediately; all outputs at reset values.
